fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
//  Issues one word request at a time to a variable-latency instruction memory.
//  Holds the fetched word, with its PC, for decode.
//  Applies decode's branch/jump redirect using MIPS single-delay-slot semantics.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset (word aligned)
// PORTS
//  clk              in   1   core clock
//  rst              in   1   synchronous, active-high reset
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   memory accepts request this cycle
//  imem_addr        out  32  fetch byte address; bits [1:0] always 0
//  imem_resp_valid  in   1   response word valid (one per accepted request)
//  imem_resp_data   in   32  response instruction word
//  stall            in   1   decode stall; IF/ID must hold
//  jump_branch      in   1   decode: conditional branch taken
//  jump_target      in   1   decode: J/JAL
//  jump_reg         in   1   decode: JR/JALR
//  jr_pc            in   32  decode: forwarded rs value for JR/JALR
//  pc_id            out  32  PC of instr_id
//  instr_id         out  32  instruction presented to decode (0 = NOP when bubble)
//  instr_valid_id   out  1   instr_id is a real instruction
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=REQ, fetch_pc=RESET_PC, pc_id=0, instr_id=0, instr_valid_id=0,
//   redir_pend=0, skid buffer empty. imem_req_valid=1 in the first cycle after reset.
//  FSM (at most one request outstanding):
//   REQ : req_valid=1, addr=fetch_pc; req_ready -> WAIT, else stay.
//   WAIT: resp_valid & ~stall -> ACCEPT resp, -> REQ; resp_valid & stall -> save to skid, -> HOLD.
//   HOLD: ~stall -> ACCEPT skid word, -> REQ; stall -> stay.
//   imem_resp_valid outside WAIT is ignored.
//  ACCEPT: pc_id<=fetch_pc; instr_id<=word; instr_valid_id<=1; fetch_pc<=next_pc.
//  IF/ID update when not accepting:
//   stall=1: pc_id, instr_id and instr_valid_id hold.
//   stall=0: load a bubble (instr_id=0, valid=0, pc_id holds).
//  Redirect capture: a taken jump is consumed from ID when instr_valid_id & ~stall &
//   (jump_branch|jump_target|jump_reg), on the cycle ID advances.
//  Target (pc4 = pc_id+4):
//   jump_reg: {jr_pc[31:2],2'b00}
//   jump_target: {pc4[31:28],instr_id[25:0],2'b00}
//   jump_branch: pc4 + {{14{instr_id[15]}},instr_id[15:0],2'b00}
//   Priority jump_reg > jump_target > jump_branch. Arithmetic is 32-bit modulo.
//  Redirect timing: the first instruction accepted after the consuming cycle is the delay slot.
//  next_pc at that instruction's ACCEPT:
//   consume same cycle as ACCEPT -> target (not registered).
//   else redir_pend -> redir_pc, and clear redir_pend.
//   else fetch_pc+4.
//  If the consume happens with no ACCEPT that cycle, set redir_pend=1, redir_pc=target.
//  fetch_pc+4 wraps 32'hFFFF_FFFC -> 0.
//  Branch in a delay slot is architecturally undefined; the block need not handle it.
//  Reset mid-request abandons any outstanding request; memory is reset with the core.
//  Latency: an accepted request whose response arrives N cycles later with stall=0
//   appears on instr_id the cycle after the response.
// TESTING
//  1 Reset, then req_ready=1 and 1-cycle response -> imem_addr 0,4,8,...
//    instr_id follows each response, instr_valid_id=1, pc_id matches each address.
//  2 Response arrives while stall=1 for 3 cycles -> instr_id/pc_id hold.
//    Word enters IF/ID the cycle stall drops; no request issued during HOLD; nothing lost.
//  3 BEQ at pc 0x10, offset 0x0004, taken -> delay slot at 0x14 fetched.
//    The next fetch address is 0x24 (0x14+0x10).
//  4 J at 0x100, instr_index 0x0000040 -> fetches 0x104 then 0x100.
//    JR at 0x200 with jr_pc=0x8003 -> fetches 0x204 then 0x8000.
//  5 Taken branch consumed while the delay-slot response is 4 cycles late -> redir_pend set.
//    Delay slot delivered, then the next fetch is the target; redir_pend cleared.
//  6 rst asserted in WAIT with a response arriving the same cycle -> response dropped.
//    Outputs at reset values; next imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS
//   core. Keeps at most one word request outstanding to a variable-latency
//   instruction memory. Parks a response that arrives while decode is stalled
//   in a one-entry skid register. Applies decode's branch/jump redirects with
//   single-delay-slot semantics.
//
// Ports
//   clk, rst           core clock, synchronous active-high reset
//   imem_req_valid     fetch request valid (only in REQ)
//   imem_req_ready     memory accepts the request this cycle
//   imem_addr          fetch byte address, word aligned
//   imem_resp_valid    response word valid (one per accepted request)
//   imem_resp_data     response instruction word
//   stall              decode stall, IF/ID holds
//   jump_branch        decode: conditional branch taken
//   jump_target        decode: J/JAL
//   jump_reg           decode: JR/JALR
//   jr_pc              decode: forwarded rs value for JR/JALR
//   pc_id              PC of instr_id
//   instr_id           instruction presented to decode (0 when bubble)
//   instr_valid_id     instr_id is a real instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        instr_valid_id
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q;
  logic [31:0] pc_id_q;
  logic [31:0] instr_id_q;
  logic        instr_valid_q;
  logic        redir_pend_q;
  logic [31:0] redir_pc_q;
  logic [31:0] skid_q;

  logic        accept;
  logic [31:0] accept_word;
  logic        consume;
  logic [31:0] pc4;
  logic [31:0] target;
  logic [31:0] next_pc;

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    accept_word = imem_resp_data;
    unique case (state_q)
      S_REQ:  if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_resp_valid) begin
          accept  = ~stall;
          state_d = stall ? S_HOLD : S_REQ;
        end
      end
      S_HOLD: begin
        accept_word = skid_q;
        if (!stall) begin
          accept  = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // The jump in ID leaves decode this cycle; its target steers the fetch
    // that follows the delay slot.
    consume = instr_valid_q & ~stall & (jump_branch | jump_target | jump_reg);
    pc4     = pc_id_q + 32'd4;
    if (jump_reg)
      target = jr_pc & 32'hFFFF_FFFC;
    else if (jump_target)
      target = {pc4[31:28], instr_id_q[25:0], 2'b00};
    else
      target = pc4 + {{14{instr_id_q[15]}}, instr_id_q[15:0], 2'b00};

    // Evaluated only when a word is accepted: that word is the delay slot if
    // a jump is consumed now or one was consumed earlier and is pending.
    if (consume)
      next_pc = target;
    else if (redir_pend_q)
      next_pc = redir_pc_q;
    else
      next_pc = fetch_pc_q + 32'd4;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC & 32'hFFFF_FFFC;
      pc_id_q       <= 32'd0;
      instr_id_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      redir_pend_q  <= 1'b0;
      redir_pc_q    <= 32'd0;
      skid_q        <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT && imem_resp_valid && stall)
        skid_q <= imem_resp_data;

      if (accept) begin
        pc_id_q       <= fetch_pc_q;
        instr_id_q    <= accept_word;
        instr_valid_q <= 1'b1;
        fetch_pc_q    <= next_pc;
        redir_pend_q  <= 1'b0;
      end else begin
        if (!stall) begin
          // ID advances with nothing new: insert a bubble, pc_id holds.
          instr_id_q    <= 32'd0;
          instr_valid_q <= 1'b0;
        end
        if (consume) begin
          redir_pend_q <= 1'b1;
          redir_pc_q   <= target;
        end
      end
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = fetch_pc_q;
  assign pc_id          = pc_id_q;
  assign instr_id       = instr_id_q;
  assign instr_valid_id = instr_valid_q;

endmodule
